// File: rtl/test_out_vcbuf_if.sv
// Flit-side bundle between the router output port, the per-VC buffer and the test output interface.
// The router/output side uses master; the buffer uses slave.
interface test_out_vcbuf_if #(
  parameter int nVCs     = 2,
  parameter int VC_WIDTH = 1,
  parameter int TS_WIDTH = 8
);
  logic                     in_valid;
  logic [VC_WIDTH-1:0]      in_vc;
  logic [TS_WIDTH-1:0]      in_ts;
  logic [TS_WIDTH-1:0]      sim_time;
  logic                     sink_ready;
  logic [nVCs*TS_WIDTH-1:0] flit_ts;
  logic [nVCs-1:0]          flit_valid;
  logic [nVCs-1:0]          credit_out;

  modport master (
    output in_valid, in_vc, in_ts, sim_time, sink_ready,
    input  flit_ts, flit_valid, credit_out
  );

  modport slave (
    input  in_valid, in_vc, in_ts, sim_time, sink_ready,
    output flit_ts, flit_valid, credit_out
  );
endinterface

// File: rtl/test_out_vcbuf.sv
// Per-VC circular flit buffer that releases heads once sim_time reaches their timestamp.
// Define OUT_VCBUF_STATS_EN to build the released-flit counter on stat_count.
module test_out_vcbuf #(
  parameter int nVCs      = 2,
  parameter int VC_WIDTH  = 1,
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2,
  parameter int TS_WIDTH  = 8
) (
  input  logic            clock,
  input  logic            reset,
  test_out_vcbuf_if.slave bus,
  output logic            overflow,
  output logic [31:0]     stat_count
);
  typedef logic [TS_WIDTH-1:0]  ts_t;
  typedef logic [LOG_DEPTH-1:0] ptr_t;
  typedef logic [LOG_DEPTH:0]   cnt_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  ts_t             mem_r        [nVCs][DEPTH];
  ptr_t            rd_ptr_r     [nVCs];
  ptr_t            wr_ptr_r     [nVCs];
  cnt_t            count_r      [nVCs];
  ts_t             head_r       [nVCs];
  logic [nVCs-1:0] valid_r;
  logic [nVCs-1:0] credit_r;
  logic            overflow_r;

  logic [nVCs-1:0] hit_s;
  logic [nVCs-1:0] push_s;
  logic [nVCs-1:0] drop_s;
  logic [nVCs-1:0] pop_s;
  ptr_t            rd_next_s    [nVCs];
  ptr_t            wr_next_s    [nVCs];
  cnt_t            count_next_s [nVCs];
  ts_t             head_next_s  [nVCs];

  // Per-VC push/drop/pop decisions and next pointer, count and head values.
  always_comb begin
    hit_s  = {nVCs{1'b0}};
    push_s = {nVCs{1'b0}};
    drop_s = {nVCs{1'b0}};
    pop_s  = {nVCs{1'b0}};
    for (int v = 0; v < nVCs; v++) begin
      rd_next_s[v]    = rd_ptr_r[v];
      wr_next_s[v]    = wr_ptr_r[v];
      count_next_s[v] = count_r[v];
      head_next_s[v]  = {TS_WIDTH{1'b0}};
    end
    for (int v = 0; v < nVCs; v++) begin
      hit_s[v]  = bus.in_valid && (bus.in_vc == VC_WIDTH'(v));
      // Full check uses the pre-pop count so a same-cycle pop never frees a slot.
      push_s[v] = hit_s[v] && (count_r[v] != FULL);
      drop_s[v] = hit_s[v] && (count_r[v] == FULL);
      // Wrap-aware head_ts <= sim_time: the modular difference must be non-negative.
      pop_s[v]  = bus.sink_ready && valid_r[v] &&
                  ($signed(bus.sim_time - head_r[v]) >= $signed({TS_WIDTH{1'b0}}));
      rd_next_s[v]    = rd_ptr_r[v] + ptr_t'(pop_s[v]);
      wr_next_s[v]    = wr_ptr_r[v] + ptr_t'(push_s[v]);
      count_next_s[v] = count_r[v] + cnt_t'(push_s[v]) - cnt_t'(pop_s[v]);
      if (count_next_s[v] == {(LOG_DEPTH+1){1'b0}}) begin
        head_next_s[v] = {TS_WIDTH{1'b0}};
      end else if (push_s[v] && (wr_ptr_r[v] == rd_next_s[v])) begin
        // Incoming flit lands exactly on the new head slot.
        head_next_s[v] = bus.in_ts;
      end else begin
        head_next_s[v] = mem_r[v][rd_next_s[v]];
      end
    end
  end

  // Flit storage; contents survive reset because the pointers define validity.
  always_ff @(posedge clock) begin
    for (int v = 0; v < nVCs; v++) begin
      if (push_s[v]) begin
        mem_r[v][wr_ptr_r[v]] <= bus.in_ts;
      end
    end
  end

  // Pointers, counts, registered head view, credit pulses and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int v = 0; v < nVCs; v++) begin
        rd_ptr_r[v] <= {LOG_DEPTH{1'b0}};
        wr_ptr_r[v] <= {LOG_DEPTH{1'b0}};
        count_r[v]  <= {(LOG_DEPTH+1){1'b0}};
        head_r[v]   <= {TS_WIDTH{1'b0}};
      end
      valid_r    <= {nVCs{1'b0}};
      credit_r   <= {nVCs{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      for (int v = 0; v < nVCs; v++) begin
        rd_ptr_r[v] <= rd_next_s[v];
        wr_ptr_r[v] <= wr_next_s[v];
        count_r[v]  <= count_next_s[v];
        head_r[v]   <= head_next_s[v];
        valid_r[v]  <= (count_next_s[v] != {(LOG_DEPTH+1){1'b0}});
      end
      credit_r   <= pop_s;
      overflow_r <= overflow_r | (|drop_s);
    end
  end

  for (genvar g = 0; g < nVCs; g++) begin : g_ts
    assign bus.flit_ts[g*TS_WIDTH +: TS_WIDTH] = head_r[g];
  end
  assign bus.flit_valid = valid_r;
  assign bus.credit_out = credit_r;
  assign overflow       = overflow_r;

`ifdef OUT_VCBUF_STATS_EN
  logic [31:0] stat_r;
  logic [31:0] pop_num_s;

  // Number of VCs releasing a flit this cycle.
  always_comb begin
    pop_num_s = 32'd0;
    for (int v = 0; v < nVCs; v++) begin
      pop_num_s = pop_num_s + 32'(pop_s[v]);
    end
  end

  // Released-flit counter, wraps at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_r <= 32'd0;
    end else begin
      stat_r <= stat_r + pop_num_s;
    end
  end

  assign stat_count = stat_r;
`else
  assign stat_count = 32'd0;
`endif
endmodule

// File: tb/tb_test_out_vcbuf.sv
// Scoreboard bench for test_out_vcbuf: a queue-based model predicts each cycle's outputs,
// a negedge monitor compares them against the DUT.
module tb_test_out_vcbuf;
  localparam int NV    = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        overflow;
  logic [31:0] stat_count;

  test_out_vcbuf_if #(.nVCs(NV), .VC_WIDTH(1), .TS_WIDTH(8)) bus ();

  test_out_vcbuf #(.nVCs(NV), .VC_WIDTH(1), .DEPTH(DEPTH), .LOG_DEPTH(2), .TS_WIDTH(8)) dut (
    .clock(clk), .reset(reset), .bus(bus), .overflow(overflow), .stat_count(stat_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  valid;
    logic [15:0] ts;
    logic [1:0]  credit;
    logic        ovf;
    logic [31:0] stat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model state: visible FIFO contents per VC plus pending observables.
  logic [7:0]  mq[NV][$];
  logic [1:0]  m_credit = 2'b00;
  logic        m_ovf    = 1'b0;
  logic [31:0] m_stat   = 32'd0;
  bit          m_known  = 1'b0;

  function automatic bit reached(input int h, input int st);
    return ((st - h) & 255) < 128;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("flit_valid", {30'd0, bus.flit_valid}, {30'd0, mon_e.valid});
      chk("flit_ts",    {16'd0, bus.flit_ts},    {16'd0, mon_e.ts});
      chk("credit_out", {30'd0, bus.credit_out}, {30'd0, mon_e.credit});
      chk("overflow",   {31'd0, overflow},       {31'd0, mon_e.ovf});
      chk("stat_count", stat_count,              mon_e.stat);
    end
  end

  task automatic step(input logic v, input logic [0:0] vc, input logic [7:0] ts,
                      input logic [7:0] st, input logic rdy, input logic rst);
    exp_t       e;
    int         npop;
    logic [1:0] ncred;
    bit         full_pre;
    bus.in_valid   = v;
    bus.in_vc      = vc;
    bus.in_ts      = ts;
    bus.sim_time   = st;
    bus.sink_ready = rdy;
    reset          = rst;
    e = '0;
    for (int k = 0; k < NV; k++) begin
      e.valid[k]       = (mq[k].size() != 0);
      e.ts[k*8 +: 8]   = (mq[k].size() != 0) ? mq[k][0] : 8'h00;
    end
    e.credit = m_credit;
    e.ovf    = m_ovf;
    e.stat   = m_stat;
    if (m_known) exp_q.push_back(e);
    full_pre = (mq[vc].size() >= DEPTH);
    ncred = 2'b00;
    npop  = 0;
    for (int k = 0; k < NV; k++) begin
      if (rdy && mq[k].size() > 0 && reached(int'(mq[k][0]), int'(st))) begin
        void'(mq[k].pop_front());
        ncred[k] = 1'b1;
        npop++;
      end
    end
    if (v) begin
      if (full_pre) m_ovf = 1'b1;
      else mq[vc].push_back(ts);
    end
`ifdef OUT_VCBUF_STATS_EN
    m_stat = m_stat + 32'(npop);
`endif
    m_credit = ncred;
    if (rst) begin
      mq[0].delete();
      mq[1].delete();
      m_credit = 2'b00;
      m_ovf    = 1'b0;
      m_stat   = 32'd0;
    end
    m_known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] st;

  initial begin
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    // Single flit released exactly when sim_time reaches its timestamp.
    step(1'b1, 1'b0, 8'd5, 8'd3, 1'b1, 1'b0);
    for (int t = 3; t <= 7; t++) step(1'b0, 1'b0, 8'd0, 8'(t), 1'b1, 1'b0);
    // Fill VC1, overflow on the fifth push, then drain in order.
    for (int t = 1; t <= 5; t++) step(1'b1, 1'b1, 8'(t), 8'd0, 1'b0, 1'b0);
    for (int t = 0; t < 6; t++) step(1'b0, 1'b0, 8'd0, 8'd10, 1'b1, 1'b0);
    // Both VCs eligible in the same cycle.
    step(1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'd2, 8'd0, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++) step(1'b0, 1'b0, 8'd0, 8'd2, 1'b1, 1'b0);
    // Timestamp wrap-around in both directions.
    step(1'b1, 1'b0, 8'hFE, 8'hF0, 1'b0, 1'b0);
    for (int t = 0; t < 2; t++) step(1'b0, 1'b0, 8'd0, 8'h02, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h02, 8'hFE, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++) step(1'b0, 1'b0, 8'd0, 8'hFE, 1'b1, 1'b0);
    for (int t = 0; t < 2; t++) step(1'b0, 1'b0, 8'd0, 8'h02, 1'b1, 1'b0);
    // Simultaneous push and pop on a VC holding two flits.
    step(1'b1, 1'b0, 8'd10, 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'd11, 8'd0, 1'b0, 1'b0);
    for (int t = 12; t <= 14; t++) step(1'b1, 1'b0, 8'(t), 8'd20, 1'b1, 1'b0);
    for (int t = 0; t < 3; t++) step(1'b0, 1'b0, 8'd0, 8'd20, 1'b1, 1'b0);
    // Reset with flits queued, then restart from empty.
    for (int t = 0; t < 3; t++) step(1'b1, 1'b1, 8'd50, 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'd9, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 8'd60, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'd7, 8'd0, 1'b0, 1'b0);
    for (int t = 0; t < 2; t++) step(1'b0, 1'b0, 8'd0, 8'd7, 1'b1, 1'b0);
    // Randomized traffic against the model.
    st = 8'd0;
    for (int i = 0; i < 600; i++) begin
      logic [7:0] ts;
      st = st + 8'($urandom_range(0, 2));
      ts = st + 8'($urandom_range(0, 8)) - 8'd3;
      if ($urandom_range(0, 15) == 0) ts = 8'($urandom);
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ts, st,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/test_out_vcbuf.md
# test_out_vcbuf

Per-VC flit buffer directly upstream of the test output interface. It accepts timestamped flits from a router output port and queues them in one circular FIFO per virtual channel. It presents each VC's head timestamp and valid to the output interface, and releases a head flit once its timestamp has been reached by simulation time. Each release returns one credit per VC to the router.

## Interface
Parameters:
- nVCs, 2, number of virtual channels
- VC_WIDTH, 1, bits of VC index (ceil(log2(nVCs)), min 1)
- DEPTH, 4, flits per VC FIFO (power of two)
- LOG_DEPTH, 2, log2(DEPTH)
- TS_WIDTH, from const.v, timestamp width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  flit arriving this cycle
- in_vc  in  VC_WIDTH  target VC of arriving flit
- in_ts  in  TS_WIDTH  timestamp of arriving flit
- sim_time  in  TS_WIDTH  current simulation time
- sink_ready  in  1  output interface can accept releases this cycle
- flit_ts  out  nVCs*TS_WIDTH  head timestamp per VC, VC v at [v*TS_WIDTH +: TS_WIDTH]
- flit_valid  out  nVCs  VC v FIFO non-empty
- credit_out  out  nVCs  one-cycle credit pulse per released flit
- overflow  out  1  sticky: push to a full VC was dropped
- stat_count  out  32  total flits released (see Configuration)

## Operation
- Per VC: storage DEPTH x TS_WIDTH, rd_ptr/wr_ptr of LOG_DEPTH bits, count of LOG_DEPTH+1 bits.
- Push: in_valid=1 and count[in_vc] < DEPTH -> write in_ts at wr_ptr and increment wr_ptr (wraps DEPTH-1 -> 0).
- Push with count[in_vc] == DEPTH -> flit dropped, overflow set; overflow stays set until reset.
- in_vc >= nVCs is ignored. No store, no overflow.
- Eligibility of VC v: flit_valid[v]=1 and (sim_time - head_ts[v]) mod 2^TS_WIDTH has MSB = 0. This is a wrap-aware "head_ts <= sim_time" test; head_ts == sim_time is eligible.
- Release: when sink_ready=1, every eligible VC pops its head this cycle, with independent per-VC pops and no arbitration. rd_ptr increments with wrap.
- credit_out[v] pulses the cycle after each pop of VC v.
- Push and pop on the same VC in the same cycle: both take effect and count is unchanged.
  - If that VC was full, the push is still rejected, because the full check uses the pre-pop count. This is conservative and matches the credit protocol.
- flit_ts for an empty VC is driven 0.
- Reset clears pointers, counts, credit_out, overflow and stat_count. Storage contents are not cleared.
- Reset asserted mid-operation discards all queued flits; no credits are returned for them.

## Timing
- Reset values: flit_valid=0, flit_ts=0, credit_out=0, overflow=0, stat_count=0.
- Push to visible head: 1 cycle. A flit written at edge N appears on flit_valid/flit_ts after edge N, i.e. in cycle N+1.
- Release decision is combinational on the current head, sim_time and sink_ready, and takes effect at the next edge.
  - The next head appears the cycle after the pop.
  - Peak release rate: one flit per VC per cycle.
- credit_out is registered: pulse 1 cycle after the pop edge, 1 cycle wide.
- overflow rises in the cycle after the rejected push.
- sim_time may change every cycle; eligibility is evaluated every cycle.

## Configuration
- OUT_VCBUF_STATS_EN defined:
  - stat_count increments by the number of VCs popped each cycle.
  - 32-bit, wraps at 2^32.
- OUT_VCBUF_STATS_EN undefined:
  - stat_count tied to 0 and no counter logic is built.
  - All other behaviour is identical.

## Test plan
- Reset, then push VC0 ts=5 with sim_time=3, sink_ready=1:
  - flit_valid=2'b01 and flit_ts[0]=5 from the next cycle.
  - No pop until sim_time=5.
  - Pop at that edge; credit_out=2'b01 for one cycle after it; flit_valid returns to 0.
- Fill VC1 with ts 1,2,3,4 (DEPTH=4), then push a fifth:
  - Fifth push dropped and overflow=1 sticky.
  - With sim_time=10 and sink_ready=1, four pops on consecutive cycles in order 1,2,3,4; four credit_out[1] pulses.
- VC0 head ts=2 and VC1 head ts=2, sim_time=2, sink_ready=1:
  - Both pop in the same cycle; credit_out=2'b11.
  - stat_count += 2 with OUT_VCBUF_STATS_EN, stays 0 without it.
- Wrap-around: TS_WIDTH=8, head ts=8'hFE, sim_time=8'h02 -> eligible and pops. Head ts=8'h02, sim_time=8'hFE -> held.
- VC0 holding 2 flits, simultaneous push and eligible pop on VC0 for 3 cycles: count stays 2, FIFO order is preserved, and 3 credits are returned.
- Reset asserted with 3 flits queued:
  - Next cycle flit_valid=0, no credit pulses, overflow=0.
  - A subsequent push behaves as from an empty FIFO.
